// File: rtl/pwm_fade_controller_if.sv
// Control/status bundle between a fade requester and the PWM fade controller.
interface pwm_fade_controller_if #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
);
  logic                 Wrap_i;
  logic                 Start_i;
  logic [WIDTH-1:0]     Target_i;
  logic [WIDTH-1:0]     Step_i;
  logic [DIV_WIDTH-1:0] Periods_i;
  logic                 Abort_i;
  logic [WIDTH-1:0]     Compare_o;
  logic                 Busy_o;
  logic                 Done_o;

  // Requester side: issues fades and watches progress.
  modport master (
    output Wrap_i, Start_i, Target_i, Step_i, Periods_i, Abort_i,
    input  Compare_o, Busy_o, Done_o
  );

  // Controller side.
  modport slave (
    input  Wrap_i, Start_i, Target_i, Step_i, Periods_i, Abort_i,
    output Compare_o, Busy_o, Done_o
  );
endinterface

// File: rtl/pwm_fade_controller.sv
// PWM fade controller: walks the PWM compare value toward a target by a
// fixed step every N PWM periods, saturating at the target in either
// direction. Compare updates land on the edge ending the wrap cycle so the
// PWM uses the new value for the whole following period.
module pwm_fade_controller #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic Clock,
  input  logic Reset,
  pwm_fade_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0]     target;
    logic [WIDTH-1:0]     step;
    logic [DIV_WIDTH-1:0] periods;
  } fade_req_t;

  state_t               state;
  fade_req_t            req_q;
  logic [DIV_WIDTH-1:0] per_cnt;
  logic [WIDTH-1:0]     cmp_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DIV_WIDTH:0]   cnt_inc;
  logic                 step_now;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     next_cmp;

  // Next compare value toward the target; the up-sum carries an extra bit so
  // it can never wrap past all-ones, and the down path clamps before underflow.
  always_comb begin
    cnt_inc  = {1'b0, per_cnt} + (DIV_WIDTH+1)'(1);
    step_now = (cnt_inc >= {1'b0, req_q.periods});
    sum      = {1'b0, cmp_q} + {1'b0, req_q.step};
    next_cmp = cmp_q;
    if (cmp_q < req_q.target)
      next_cmp = (sum >= {1'b0, req_q.target}) ? req_q.target : sum[WIDTH-1:0];
    else if (cmp_q > req_q.target)
      next_cmp = ((cmp_q - req_q.target) <= req_q.step) ? req_q.target
                                                         : cmp_q - req_q.step;
  end

  // Fade FSM with registered outputs; Abort wins over a coincident step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      req_q   <= '0;
      per_cnt <= '0;
      cmp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.Start_i) begin
            // Zero step/periods would stall the fade forever; treat as 1.
            req_q.target  <= bus.Target_i;
            req_q.step    <= (bus.Step_i == '0) ? WIDTH'(1) : bus.Step_i;
            req_q.periods <= (bus.Periods_i == '0) ? DIV_WIDTH'(1) : bus.Periods_i;
            per_cnt       <= '0;
            if (bus.Target_i == cmp_q) begin
              state  <= DONE;
              done_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state  <= WAIT;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.Abort_i) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.Wrap_i) begin
            if (step_now) begin
              cmp_q   <= next_cmp;
              per_cnt <= '0;
              if (next_cmp == req_q.target) begin
                state  <= DONE;
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end
            end else begin
              per_cnt <= cnt_inc[DIV_WIDTH-1:0];
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Compare_o = cmp_q;
  assign bus.Busy_o    = busy_q;
  assign bus.Done_o    = done_q;

endmodule
